// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default parameters,
// FSM state encoding and the NOP encoding.
package if_fetch_stage_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_QDEPTH     = 2;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/if_fetch_stage_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   push, din       write din at the tail
//   pop             drop the head
//   flush           empty the queue; wins over push and pop
//   head            current head entry, zero when empty
//   full, empty     occupancy flags
module fetch_queue #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update. DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational IRAM,
// queues {pc, instr} toward decode and handles execute redirects.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   imem_addr       IRAM word address (pc[ADDR_WIDTH+1:2])
//   imem_data       IRAM read data, same cycle
//   redirect_valid  execute redirect request
//   redirect_pc     redirect target byte address
//   id_valid        head valid toward decode
//   id_ready        decode accepts head
//   id_instr, id_pc head instruction and its PC (zero when empty)
//   fetch_misalign  sticky flag: last redirect target was misaligned
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter int unsigned      QDEPTH     = DEF_QDEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0]      imem_data,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [WIDTH-1:0]      id_instr,
  output logic [WIDTH-1:0]      id_pc,
  output logic                  fetch_misalign
);

  localparam int unsigned EW = 2 * WIDTH;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic             misalign_nxt;
  logic             push, pop, flush;
  logic             full, empty;
  logic [EW-1:0]    head;

  fetch_queue #(.DW(EW), .DEPTH(QDEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc, imem_data}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Redirect cycle masks the head so no stale fetch reaches decode.
  assign id_valid  = !empty && !redirect_valid && (state == ST_RUN);
  assign pop       = id_valid && id_ready;
  assign id_pc     = head[EW-1:WIDTH];
  assign id_instr  = head[WIDTH-1:0];
  assign imem_addr = pc[ADDR_WIDTH+1:2];

  // State, PC and sticky-flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_RUN;
      pc             <= RESET_PC;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      fetch_misalign <= misalign_nxt;
    end
  end

  // Next-state and queue control; redirect outranks fetching.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    misalign_nxt = fetch_misalign;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_nxt    = ST_HALT;
        misalign_nxt = 1'b1;
      end else begin
        state_nxt    = ST_RUN;
        misalign_nxt = 1'b0;
        pc_nxt       = redirect_pc;
      end
    end else if (state == ST_RUN) begin
      push = !full || pop;
      if (push) pc_nxt = pc + WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned AWD = 8;
  localparam int unsigned QD  = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [AWD-1:0] imem_addr;
  logic [W-1:0]   imem_data;
  logic           redirect_valid = 1'b0;
  logic [W-1:0]   redirect_pc = '0;
  logic           id_valid;
  logic           id_ready = 1'b0;
  logic [W-1:0]   id_instr;
  logic [W-1:0]   id_pc;
  logic           fetch_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  if_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_misalign (fetch_misalign)
  );

  // IRAM contents: three real instructions, NOP at the last word, tagged words elsewhere.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'd0) return 32'h0000_2083;
    if (a == 8'd1) return 32'h0010_a103;
    if (a == 8'd2) return 32'h0020_81b3;
    if (a == 8'd255) return NOP;
    return {16'hA5A5, 8'h00, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  // Reference model: plain queue of {pc, instr} plus PC and halt/misalign flags.
  logic [63:0] m_q[$];
  logic [31:0] m_pc   = '0;
  bit          m_halt = 1'b0;
  bit          m_mis  = 1'b0;

  function automatic void model_step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit do_pop;
    if (r) begin
      m_q.delete();
      m_pc = '0; m_halt = 1'b0; m_mis = 1'b0;
    end else if (rv) begin
      m_q.delete();
      if (rpc[1:0] != 2'b00) begin
        m_halt = 1'b1; m_mis = 1'b1;
      end else begin
        m_pc = rpc; m_halt = 1'b0; m_mis = 1'b0;
      end
    end else if (!m_halt) begin
      do_pop = (m_q.size() > 0) && rdy;
      if (m_q.size() < QD || do_pop) begin
        if (do_pop) void'(m_q.pop_front());
        m_q.push_back({m_pc, mem_word(m_pc[9:2])});
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic        ev;
    logic [63:0] eh;
    ev = (m_q.size() > 0) && !redirect_valid && !m_halt;
    eh = (m_q.size() > 0) ? m_q[0] : 64'h0;
    check("model id_valid", 64'(id_valid), 64'(ev));
    check("model id_pc", 64'(id_pc), 64'(eh[63:32]));
    check("model id_instr", 64'(id_instr), 64'(eh[31:0]));
    check("model imem_addr", 64'(imem_addr), 64'(m_pc[9:2]));
    check("model fetch_misalign", 64'(fetch_misalign), 64'(m_mis));
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          chk;
    bit          ev;
    logic [31:0] epc;
    bit          emis;
  } vec_t;

  localparam int NV = 30;
  vec_t tv[NV];

  function automatic vec_t mk(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit chk, input bit ev, input logic [31:0] epc, input bit emis);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.chk = chk; v.ev = ev; v.epc = epc; v.emis = emis;
    return v;
  endfunction

  initial begin
    logic [31:0] rpc;
    bit r, rdy, rv;

    // Expected values are the outputs seen before the edge that applies the row's inputs.
    tv[0]  = mk(1, 1, 0, 0,      0, 0, 0,      0);
    tv[1]  = mk(1, 1, 0, 0,      1, 0, 0,      0);
    tv[2]  = mk(0, 1, 0, 0,      1, 0, 0,      0);
    tv[3]  = mk(0, 1, 0, 0,      1, 1, 0,      0);
    tv[4]  = mk(0, 1, 0, 0,      1, 1, 4,      0);
    tv[5]  = mk(0, 0, 0, 0,      1, 1, 8,      0);
    tv[6]  = mk(0, 0, 0, 0,      1, 1, 8,      0);
    tv[7]  = mk(0, 0, 0, 0,      1, 1, 8,      0);
    tv[8]  = mk(0, 0, 0, 0,      1, 1, 8,      0);
    tv[9]  = mk(0, 0, 0, 0,      1, 1, 8,      0);
    tv[10] = mk(0, 1, 0, 0,      1, 1, 8,      0);
    tv[11] = mk(0, 1, 0, 0,      1, 1, 32'hC,  0);
    tv[12] = mk(0, 1, 1, 32'h40, 1, 0, 0,      0);
    tv[13] = mk(0, 1, 0, 0,      1, 0, 0,      0);
    tv[14] = mk(0, 1, 0, 0,      1, 1, 32'h40, 0);
    tv[15] = mk(0, 1, 1, 32'h42, 1, 0, 0,      0);
    tv[16] = mk(0, 1, 0, 0,      1, 0, 0,      1);
    tv[17] = mk(0, 1, 0, 0,      1, 0, 0,      1);
    tv[18] = mk(0, 1, 1, 32'h10, 1, 0, 0,      1);
    tv[19] = mk(0, 1, 0, 0,      1, 0, 0,      0);
    tv[20] = mk(0, 1, 0, 0,      1, 1, 32'h10, 0);
    tv[21] = mk(0, 1, 1, 32'h3FC,1, 0, 0,      0);
    tv[22] = mk(0, 1, 0, 0,      1, 0, 0,      0);
    tv[23] = mk(0, 1, 0, 0,      1, 1, 32'h3FC,0);
    tv[24] = mk(0, 1, 0, 0,      1, 1, 32'h400,0);
    tv[25] = mk(0, 0, 0, 0,      1, 1, 32'h404,0);
    tv[26] = mk(1, 1, 0, 0,      1, 1, 32'h404,0);
    tv[27] = mk(0, 1, 0, 0,      1, 0, 0,      0);
    tv[28] = mk(0, 1, 0, 0,      1, 1, 0,      0);
    tv[29] = mk(0, 1, 0, 0,      1, 1, 4,      0);

    // Directed table: startup, backpressure, redirects, misalign, wrap, mid-stream reset.
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      reset = tv[i].rst; id_ready = tv[i].rdy;
      redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      #1;
      if (tv[i].chk) begin
        check($sformatf("row%0d id_valid", i), 64'(id_valid), 64'(tv[i].ev));
        check($sformatf("row%0d fetch_misalign", i), 64'(fetch_misalign), 64'(tv[i].emis));
        if (tv[i].ev) begin
          check($sformatf("row%0d id_pc", i), 64'(id_pc), 64'(tv[i].epc));
          check($sformatf("row%0d id_instr", i), 64'(id_instr), 64'(mem_word(tv[i].epc[9:2])));
        end
        check_model();
      end
      model_step(tv[i].rst, tv[i].rdy, tv[i].rv, tv[i].rpc);
    end

    // Hand-written: word-255 wrap is visible on imem_addr across two fetches.
    @(negedge clock);
    reset = 1'b0; id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    #1; check_model(); model_step(0, 1, 1, 32'h3FC);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1; check("wrap imem_addr 255", 64'(imem_addr), 64'd255); check_model(); model_step(0, 1, 0, 0);
    @(negedge clock);
    #1; check("wrap imem_addr 0", 64'(imem_addr), 64'd0);
    check("wrap head instr NOP", 64'(id_instr), 64'(NOP)); check_model(); model_step(0, 1, 0, 0);

    // Randomized traffic against the model, including 32-bit PC wrap targets.
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = 32'h0000_03F8;
        2:       rpc = {$urandom_range(0, 300), 2'b00} | 32'($urandom_range(1, 3));
        default: rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      @(negedge clock);
      reset = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      check_model();
      model_step(r, rdy, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
